// File: rtl/ifetch_line_cache.sv
// Instruction fetch: direct-mapped multi-word-line cache feeding a small decoder queue.
// Refills are issued word by word to the memory controller and can be aborted by a redirect.
module ifetch_line_cache #(
   parameter int ADDR_W      = 32,
   parameter int INST_W      = 32,
   parameter int SETS        = 64,
   parameter int LINE_WORDS  = 4,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   output logic              out_valid,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   input  logic              out_ready,
   output logic              mc_en,
   output logic [ADDR_W-1:0] mc_addr,
   input  logic              mc_done,
   input  logic [INST_W-1:0] mc_data,
   input  logic              flush_en,
   input  logic [ADDR_W-1:0] flush_pc
);

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int OFF_WS = (OFF_W == 0) ? 1 : OFF_W;
   localparam int IDX_W  = $clog2(SETS);
   localparam int DA_W   = IDX_W + OFF_W;
   localparam int TAG_W  = ADDR_W - 2 - DA_W;
   localparam int Q_W    = $clog2(QUEUE_DEPTH);
   localparam int CNT_W  = Q_W + 1;
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
   localparam logic [CNT_W-1:0]  Q_FULL    = CNT_W'(QUEUE_DEPTH);
   localparam logic [OFF_WS-1:0] LAST_OFF  = OFF_WS'(LINE_WORDS - 1);

   typedef enum logic [0:0] {IDLE = 1'b0, REFILL = 1'b1} state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] pc_r;
   logic [SETS-1:0]   valid_r;
   logic [TAG_W-1:0]  tag_r [SETS];
   logic [INST_W-1:0] data_r [SETS*LINE_WORDS];
   logic [INST_W-1:0] q_inst_r [QUEUE_DEPTH];
   logic [ADDR_W-1:0] q_pc_r [QUEUE_DEPTH];
   logic [Q_W-1:0]    head_r;
   logic [Q_W-1:0]    tail_r;
   logic [CNT_W-1:0]  count_r;
   logic              out_valid_r;
   logic [INST_W-1:0] out_inst_r;
   logic [ADDR_W-1:0] out_pc_r;
   logic              mc_en_r;
   logic [ADDR_W-1:0] mc_addr_r;

   logic [IDX_W-1:0]  idx_s;
   logic [TAG_W-1:0]  tag_s;
   logic [DA_W-1:0]   rd_addr_s;
   logic              hit_s;
   logic [INST_W-1:0] fetch_word_s;
   logic [DA_W-1:0]   fill_addr_s;
   logic [IDX_W-1:0]  fill_idx_s;
   logic [TAG_W-1:0]  fill_tag_s;
   logic [OFF_WS-1:0] fill_off_s;
   logic              last_word_s;
   logic              pop_s;
   logic              active_s;
   logic              push_s;
   logic              miss_s;
   logic              fill_s;
   logic              deq_s;
   logic [Q_W-1:0]    head_nx_s;
   logic [CNT_W-1:0]  count_nx_s;
   logic [INST_W-1:0] head_inst_s;
   logic [ADDR_W-1:0] head_pc_s;

   // The refill word address mc_addr_r already carries the set index and word offset of the fill.
   assign idx_s        = IDX_W'(pc_r >> (OFF_W + 2));
   assign tag_s        = TAG_W'(pc_r >> (DA_W + 2));
   assign rd_addr_s    = DA_W'(pc_r >> 2);
   assign hit_s        = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
   assign fetch_word_s = data_r[rd_addr_s];
   assign fill_addr_s  = DA_W'(mc_addr_r >> 2);
   assign fill_idx_s   = IDX_W'(mc_addr_r >> (OFF_W + 2));
   assign fill_tag_s   = TAG_W'(mc_addr_r >> (DA_W + 2));
   assign fill_off_s   = OFF_WS'(mc_addr_r >> 2);
   assign last_word_s  = (OFF_W == 0) ? 1'b1 : (fill_off_s == LAST_OFF);

   // Next-cycle queue and fetch decisions, including the head entry the registered outputs will show.
   always_comb begin
      pop_s    = out_valid_r && out_ready;
      active_s = rdy && !flush_en;
      push_s   = 1'b0;
      miss_s   = 1'b0;
      if (active_s && (state_r == IDLE)) begin
         if (hit_s) begin
            push_s = (count_r != Q_FULL) || pop_s;
         end else begin
            miss_s = 1'b1;
         end
      end else begin
         push_s = 1'b0;
         miss_s = 1'b0;
      end
      fill_s     = active_s && (state_r == REFILL) && mc_done;
      deq_s      = active_s && pop_s;
      head_nx_s  = deq_s ? (head_r + Q_W'(1)) : head_r;
      count_nx_s = count_r + CNT_W'(push_s) - CNT_W'(deq_s);
      if (push_s && (head_nx_s == tail_r)) begin
         head_inst_s = fetch_word_s;
         head_pc_s   = pc_r;
      end else begin
         head_inst_s = q_inst_r[head_nx_s];
         head_pc_s   = q_pc_r[head_nx_s];
      end
   end

   // Fetch state machine, PC, queue pointers, valid bits and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         pc_r        <= '0;
         valid_r     <= '0;
         head_r      <= '0;
         tail_r      <= '0;
         count_r     <= '0;
         out_valid_r <= 1'b0;
         out_inst_r  <= '0;
         out_pc_r    <= '0;
         mc_en_r     <= 1'b0;
         mc_addr_r   <= '0;
      end else if (rdy) begin
         if (flush_en) begin
            state_r     <= IDLE;
            pc_r        <= flush_pc;
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            out_valid_r <= 1'b0;
            mc_en_r     <= 1'b0;
         end else begin
            head_r      <= head_nx_s;
            count_r     <= count_nx_s;
            out_valid_r <= (count_nx_s != '0);
            out_inst_r  <= head_inst_s;
            out_pc_r    <= head_pc_s;
            if (push_s) begin
               tail_r <= tail_r + Q_W'(1);
               pc_r   <= pc_r + ADDR_W'(4);
            end
            case (state_r)
               IDLE: begin
                  if (miss_s) begin
                     state_r        <= REFILL;
                     valid_r[idx_s] <= 1'b0;
                     mc_en_r        <= 1'b1;
                     mc_addr_r      <= pc_r & ~LINE_MASK;
                  end
               end
               REFILL: begin
                  if (mc_done) begin
                     mc_addr_r <= mc_addr_r + ADDR_W'(4);
                     if (last_word_s) begin
                        valid_r[fill_idx_s] <= 1'b1;
                        mc_en_r             <= 1'b0;
                        state_r             <= IDLE;
                     end
                  end
               end
               default: begin
                  state_r <= IDLE;
                  mc_en_r <= 1'b0;
               end
            endcase
         end
      end
   end

   // Payload storage carries no reset; valid bits and the queue count qualify it.
   always_ff @(posedge clk) begin
      if (push_s) begin
         q_inst_r[tail_r] <= fetch_word_s;
         q_pc_r[tail_r]   <= pc_r;
      end
      if (fill_s) begin
         data_r[fill_addr_s] <= mc_data;
      end
      if (fill_s && last_word_s) begin
         tag_r[fill_idx_s] <= fill_tag_s;
      end
   end

   assign out_valid = out_valid_r;
   assign out_inst  = out_inst_r;
   assign out_pc    = out_pc_r;
   assign mc_en     = mc_en_r;
   assign mc_addr   = mc_addr_r;

endmodule
